// File: rtl/op_encoder_tx_pkg.sv
// -----------------------------------------------------------------------------
// op_encoder_tx_pkg
// Shared definitions for the monitor-to-host op encoder (and its decoder twin):
//   - op codes for the three packet types
//   - transmit FSM state encoding
//   - frame lengths in bits per packet type
// Optional feature macro: NEXTASIC_TX_PARITY_EN (adds one even-parity bit
// before the stop bit, lengthening every frame by one bit).
// -----------------------------------------------------------------------------
package op_encoder_tx_pkg;

    localparam logic [7:0] OP_AUDIO_REQ = 8'h07;  // short packet
    localparam logic [7:0] OP_MIC_DATA  = 8'hC7;  // long packet
    localparam logic [7:0] OP_KBD_DATA  = 8'hDD;  // long packet

    localparam int OP_BITS   = 8;
    localparam int DATA_BITS = 32;

`ifdef NEXTASIC_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // start + op + [parity] + stop, and the same plus the data word
    localparam int SHORT_FRAME_BITS = 1 + OP_BITS + PARITY_BITS + 1;
    localparam int LONG_FRAME_BITS  = SHORT_FRAME_BITS + DATA_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/op_encoder_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// op_encoder_tx_bit_timer
// Free-running 0..BIT_CYCLES-1 cycle counter that paces the serial line.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   restart    : synchronous restart, counter returns to 0 on the next edge
//   bit_tick   : high during the last cycle of a bit time (counter wraps after)
//   pre_tick   : high during the second-to-last cycle of a bit time, lets the
//                parent register a pulse that lands on the last cycle
// -----------------------------------------------------------------------------
module op_encoder_tx_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick,
    output logic pre_tick
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign bit_tick = (count == 8'(BIT_CYCLES - 1));
    assign pre_tick = (count == 8'(BIT_CYCLES - 2));

endmodule

// File: rtl/op_encoder_tx.sv
// -----------------------------------------------------------------------------
// op_encoder_tx
// Frames and serialises monitor-to-host packets onto the from_mon line.
// Three sources arbitrated by fixed priority (audio > mic > kbd). Each frame:
// start bit (1), 8 op bits MSB first, 32 data bits for long packets,
// [even parity], stop bit (0), then GAP_BITS idle bit times.
// Optional feature macro: NEXTASIC_TX_PARITY_EN (parity bit before stop).
// Parameters:
//   BIT_CYCLES : clock cycles per serial bit (2..255)
//   GAP_BITS   : idle bit times after each frame (0..15)
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   audio_req_valid / _ack     : audio-sample request (short packet)
//   mic_valid, mic_data, mic_ack : mic data (long packet)
//   kbd_valid, kbd_data, kbd_ack : keyboard/mouse data (long packet)
//   from_mon                   : serial output, idle 0
//   busy                       : acceptance through end of gap
//   frame_done                 : pulse on the last cycle of the stop bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module op_encoder_tx
    import op_encoder_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        audio_req_valid,
    output logic        audio_req_ack,
    input  logic        mic_valid,
    input  logic [31:0] mic_data,
    output logic        mic_ack,
    input  logic        kbd_valid,
    input  logic [31:0] kbd_data,
    output logic        kbd_ack,
    output logic        from_mon,
    output logic        busy,
    output logic        frame_done
);

    // Last bit index of the gap; unreachable when GAP_BITS is 0.
    localparam logic [5:0] GAP_LAST = (GAP_BITS == 0) ? 6'd0 : 6'(GAP_BITS - 1);

    tx_state_t   state;
    logic [5:0]  bit_idx;
    logic [39:0] shreg;     // {op, data}; bit 39 is the bit on the line
    logic        is_long;
`ifdef NEXTASIC_TX_PARITY_EN
    logic        par_bit;
`endif

    logic        bit_tick;
    logic        pre_tick;

    // Arbitration winner
    logic        any_valid;
    logic [7:0]  win_op;
    logic [31:0] win_data;
    logic        win_long;
    logic [2:0]  win_ack;   // {audio, mic, kbd}

    // What follows the last op/data bit
    tx_state_t   tail_state;
    logic        tail_bit;

    logic        frame_end;
    logic        accept;

    op_encoder_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .restart  (state == ST_IDLE),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and no latch is inferred.
        any_valid = audio_req_valid | mic_valid | kbd_valid;
        win_op    = OP_KBD_DATA;
        win_data  = kbd_data;
        win_long  = 1'b1;
        win_ack   = 3'b001;
        if (audio_req_valid) begin
            win_op   = OP_AUDIO_REQ;
            win_data = '0;
            win_long = 1'b0;
            win_ack  = 3'b100;
        end else if (mic_valid) begin
            win_op   = OP_MIC_DATA;
            win_data = mic_data;
            win_ack  = 3'b010;
        end
    end

`ifdef NEXTASIC_TX_PARITY_EN
    assign tail_state = ST_PARITY;
    assign tail_bit   = par_bit;
`else
    assign tail_state = ST_STOP;
    assign tail_bit   = 1'b0;
`endif

    // The edge that would return to IDLE can accept directly, so
    // back-to-back frames carry no dead cycle beyond the gap.
    assign frame_end = bit_tick &&
                       (((state == ST_STOP) && (GAP_BITS == 0)) ||
                        ((state == ST_GAP)  && (bit_idx == GAP_LAST)));
    assign accept    = any_valid && ((state == ST_IDLE) || frame_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_idx       <= '0;
            // NOTE: the shift register is a handful of flops, not a memory
            // array, so it is reset with the rest to keep a known state.
            shreg         <= '0;
            is_long       <= 1'b0;
`ifdef NEXTASIC_TX_PARITY_EN
            par_bit       <= 1'b0;
`endif
            from_mon      <= 1'b0;
            busy          <= 1'b0;
            audio_req_ack <= 1'b0;
            mic_ack       <= 1'b0;
            kbd_ack       <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            audio_req_ack <= 1'b0;
            mic_ack       <= 1'b0;
            kbd_ack       <= 1'b0;
            frame_done    <= (state == ST_STOP) && pre_tick;

            if (accept) begin
                state    <= ST_START;
                bit_idx  <= '0;
                shreg    <= {win_op, win_data};
                is_long  <= win_long;
`ifdef NEXTASIC_TX_PARITY_EN
                par_bit  <= ^{win_op, win_data};  // audio data is zero
`endif
                from_mon <= 1'b1;
                busy     <= 1'b1;
                {audio_req_ack, mic_ack, kbd_ack} <= win_ack;
            end else if (bit_tick) begin
                unique case (state)
                    ST_START: begin
                        state    <= ST_OP;
                        bit_idx  <= '0;
                        from_mon <= shreg[39];
                    end
                    ST_OP: begin
                        shreg <= shreg << 1;
                        if (bit_idx == 6'd7) begin
                            bit_idx <= '0;
                            if (is_long) begin
                                state    <= ST_DATA;
                                from_mon <= shreg[38];
                            end else begin
                                state    <= tail_state;
                                from_mon <= tail_bit;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 6'd1;
                            from_mon <= shreg[38];
                        end
                    end
                    ST_DATA: begin
                        shreg <= shreg << 1;
                        if (bit_idx == 6'd31) begin
                            bit_idx  <= '0;
                            state    <= tail_state;
                            from_mon <= tail_bit;
                        end else begin
                            bit_idx  <= bit_idx + 6'd1;
                            from_mon <= shreg[38];
                        end
                    end
`ifdef NEXTASIC_TX_PARITY_EN
                    ST_PARITY: begin
                        state    <= ST_STOP;
                        bit_idx  <= '0;
                        from_mon <= 1'b0;
                    end
`endif
                    ST_STOP: begin
                        bit_idx  <= '0;
                        from_mon <= 1'b0;
                        if (GAP_BITS == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (bit_idx == GAP_LAST) begin
                            state   <= ST_IDLE;
                            bit_idx <= '0;
                            busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        bit_idx  <= '0;
                        from_mon <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_op_encoder_tx.sv
// -----------------------------------------------------------------------------
// tb_op_encoder_tx
// Self-checking bench for op_encoder_tx. Expected waveforms are built from the
// frame rules: each accepted request becomes a list of bits, laid out at
// BC cycles per bit, frames queued in priority order with a gap between them.
// Recorded per cycle: {from_mon, busy, audio_ack, mic_ack, kbd_ack, frame_done}.
// -----------------------------------------------------------------------------
module tb_op_encoder_tx;

    localparam int BC   = 4;
    localparam int GAP  = 2;
    localparam int MAXN = 600;

`ifdef NEXTASIC_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int SHORT_LEN = 10 + PBITS;
    localparam int LONG_LEN  = 42 + PBITS;

    // Signal positions inside one recorded sample
    localparam int P_LINE = 5, P_BUSY = 4, P_AACK = 3, P_MACK = 2, P_KACK = 1, P_DONE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        audio_req_valid = 1'b0;
    logic        audio_req_ack;
    logic        mic_valid = 1'b0;
    logic [31:0] mic_data = '0;
    logic        mic_ack;
    logic        kbd_valid = 1'b0;
    logic [31:0] kbd_data = '0;
    logic        kbd_ack;
    logic        from_mon;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [5:0] r_sig [MAXN];
    logic [5:0] e_sig [MAXN];

    op_encoder_tx #(
        .BIT_CYCLES (BC),
        .GAP_BITS   (GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .audio_req_valid (audio_req_valid),
        .audio_req_ack   (audio_req_ack),
        .mic_valid       (mic_valid),
        .mic_data        (mic_data),
        .mic_ack         (mic_ack),
        .kbd_valid       (kbd_valid),
        .kbd_data        (kbd_data),
        .kbd_ack         (kbd_ack),
        .from_mon        (from_mon),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic place_frame(inout int t, input logic [7:0] op, input logic [31:0] d,
                               input bit is_long, input int ack_pos);
        bit fb[$];
        int len;
        bit par;
        fb.push_back(1'b1);
        for (int i = 7; i >= 0; i--) fb.push_back(op[i]);
        if (is_long) for (int i = 31; i >= 0; i--) fb.push_back(d[i]);
`ifdef NEXTASIC_TX_PARITY_EN
        par = 1'b0;
        for (int i = 1; i < fb.size(); i++) par ^= fb[i];
        fb.push_back(par);
`else
        par = 1'b0;
`endif
        fb.push_back(1'b0);
        len = fb.size();
        for (int n = 0; n < len; n++)
            for (int k = 0; k < BC; k++) e_sig[t + n*BC + k][P_LINE] = fb[n];
        for (int c = 0; c < (len + GAP)*BC; c++) e_sig[t + c][P_BUSY] = 1'b1;
        e_sig[t][ack_pos] = 1'b1;
        e_sig[t + len*BC - 1][P_DONE] = 1'b1;
        t += (len + GAP)*BC;
    endtask

    // Requests all present at the first edge; one frame each, priority order.
    task automatic model_frames(input bit a, input bit m, input bit k,
                                input logic [31:0] md, input logic [31:0] kd, output int t_end);
        int t;
        t = 0;
        for (int i = 0; i < MAXN; i++) e_sig[i] = '0;
        if (a) place_frame(t, 8'h07, 32'h0, 1'b0, P_AACK);
        if (m) place_frame(t, 8'hC7, md, 1'b1, P_MACK);
        if (k) place_frame(t, 8'hDD, kd, 1'b1, P_KACK);
        t_end = t;
    endtask

    // ---------------- stimulus / capture ----------------
    // Records n samples (one per cycle, at negedge). Acked sources drop valid
    // and scramble their data to prove the DUT captured it at acceptance.
    task automatic capture(input int n, input int drop_mic_at);
        for (int i = 0; i < n && i < MAXN; i++) begin
            @(posedge clk);
            @(negedge clk);
            r_sig[i] = {from_mon, busy, audio_req_ack, mic_ack, kbd_ack, frame_done};
            if (audio_req_ack) audio_req_valid = 1'b0;
            if (mic_ack) begin mic_valid = 1'b0; mic_data = $urandom; end
            if (kbd_ack) begin kbd_valid = 1'b0; kbd_data = $urandom; end
            if (i == drop_mic_at) mic_valid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [5:0] obs;
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {from_mon, busy, audio_req_ack, mic_ack, kbd_ack, frame_done};
        total++;
        if (obs !== 6'b0) begin
            bad++;
            $display("FAIL reset_values got=%b exp=%b", obs, 6'b0);
        end
        reset = 1'b0;
        capture(8, -1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (r_sig[i] !== 6'b0) begin
                bad++;
                $display("FAIL idle_no_req cyc=%0d got=%b exp=%b", i, r_sig[i], 6'b0);
            end
        end
    endtask

    task automatic test_audio_alone;
        int t_end;
        int busy_cnt;
        audio_req_valid = 1'b1;
        model_frames(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, t_end);
        capture(t_end + 8, -1);
        busy_cnt = 0;
        for (int i = 0; i < t_end + 8; i++) begin
            busy_cnt += int'(r_sig[i][P_BUSY]);
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL audio_alone cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
        total++;
        if (busy_cnt !== (SHORT_LEN + GAP)*BC) begin
            bad++;
            $display("FAIL audio_busy_len got=%0d exp=%0d", busy_cnt, (SHORT_LEN + GAP)*BC);
        end
    endtask

    task automatic test_kbd_edge_data;
        int t_end;
        int done_at;
        kbd_data  = 32'h8000_0001;
        kbd_valid = 1'b1;
        model_frames(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0001, t_end);
        capture(t_end + 8, -1);
        done_at = -1;
        for (int i = 0; i < t_end + 8; i++) begin
            if (r_sig[i][P_DONE] && done_at < 0) done_at = i;
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL kbd_edge cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
        // sample i is cycle i+1 after the accepting edge
        total++;
        if (done_at + 1 !== LONG_LEN*BC) begin
            bad++;
            $display("FAIL kbd_frame_done_cycle got=%0d exp=%0d", done_at + 1, LONG_LEN*BC);
        end
    endtask

    task automatic test_back_to_back;
        int t_end;
        logic [31:0] md, kd;
        md = $urandom; kd = $urandom;
        mic_data = md; kbd_data = kd;
        audio_req_valid = 1'b1; mic_valid = 1'b1; kbd_valid = 1'b1;
        model_frames(1'b1, 1'b1, 1'b1, md, kd, t_end);
        capture(t_end + 8, -1);
        for (int i = 0; i < t_end + 8; i++) begin
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
    endtask

    task automatic test_mic_withdrawn;
        int t_end;
        mic_data = $urandom;
        audio_req_valid = 1'b1; mic_valid = 1'b1;
        model_frames(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, t_end);
        capture(t_end + 40, 10);
        for (int i = 0; i < t_end + 40; i++) begin
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL mic_withdrawn cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
    endtask

    task automatic test_random;
        int t_end;
        bit a, m, k;
        logic [31:0] md, kd;
        for (int it = 0; it < 6; it++) begin
            a = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            k = 1'($urandom_range(0, 1));
            md = $urandom; kd = $urandom;
            mic_data = md; kbd_data = kd;
            audio_req_valid = a; mic_valid = m; kbd_valid = k;
            model_frames(a, m, k, md, kd, t_end);
            capture(t_end + 6, -1);
            for (int i = 0; i < t_end + 6; i++) begin
                total++;
                if (r_sig[i] !== e_sig[i]) begin
                    bad++;
                    $display("FAIL random it=%0d req=%b%b%b cyc=%0d got=%b exp=%b",
                             it, a, m, k, i, r_sig[i], e_sig[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int t_end;
        int cut;
        logic [31:0] kd;
        // data bit 20 is frame bit 29, occupying samples 116..119
        cut = 29*BC + 2;
        kd = $urandom | 32'h0000_0800;
        kbd_data = kd; kbd_valid = 1'b1;
        model_frames(1'b0, 1'b0, 1'b1, 32'h0, kd, t_end);
        capture(cut, -1);
        for (int i = 0; i < cut; i++) begin
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
        // asynchronous: the line must drop without waiting for an edge
        #1 reset = 1'b1;
        #1;
        total++;
        if ({from_mon, busy} !== 2'b00) begin
            bad++;
            $display("FAIL async_reset line_busy got=%b exp=%b", {from_mon, busy}, 2'b00);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        capture(20, -1);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (r_sig[i] !== 6'b0) begin
                bad++;
                $display("FAIL no_retry cyc=%0d got=%b exp=%b", i, r_sig[i], 6'b0);
            end
        end
        kd = $urandom;
        kbd_data = kd; kbd_valid = 1'b1;
        model_frames(1'b0, 1'b0, 1'b1, 32'h0, kd, t_end);
        capture(t_end + 8, -1);
        for (int i = 0; i < t_end + 8; i++) begin
            total++;
            if (r_sig[i] !== e_sig[i]) begin
                bad++;
                $display("FAIL post_reset_frame cyc=%0d got=%b exp=%b", i, r_sig[i], e_sig[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_audio_alone();
        test_kbd_edge_data();
        test_back_to_back();
        test_mic_withdrawn();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
